// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS fetch front end.
//   NOP_INSTR     - encoding driven on the instruction output when nothing is valid
//   OP_*          - primary opcode field values (instr[31:26])
//   XLEN_DEFAULT  - default datapath width
//   fetch_entry_t - one prefetch queue entry {instr, pc}
package mips_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  localparam logic [XLEN_DEFAULT-1:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] instr;
    logic [XLEN_DEFAULT-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo_flush.sv
// sync_fifo_flush: DEPTH x WIDTH synchronous FIFO with a flush input.
//   clk_i, rst_i - clock and synchronous active-high reset
//   flush_i      - empties the FIFO and resets pointers; overrides push/pop
//   push_i       - write wdata_i at the tail
//   pop_i        - drop the head entry (ignored when empty)
//   valid_o      - head entry present
//   rdata_o      - head entry, read straight from storage (no write bypass)
//   count_o      - occupied entries
module sync_fifo_flush #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic                       valid_o,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Pointers wrap modulo DEPTH so non-power-of-two depths work; full/empty
  // is decided by the count register alone.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    do_pop  = pop_i && (count_q != '0);
    do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (flush_i) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_pop)  rptr_d = ptr_inc(rptr_q);
      if (do_push) wptr_d = ptr_inc(wptr_q);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i && !rst_i) mem_q[wptr_q] <= wdata_i;
  end

  assign valid_o = (count_q != '0);
  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

  push_when_full_a: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && !flush_i && !pop_i && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: instruction-fetch front end (PC generator, synchronous
// instruction-memory request port, prefetch queue with flush-on-redirect).
//   clock, reset              - clock and synchronous active-high reset
//   imem_req, imem_addr       - memory read request and word address
//   imem_rdata                - memory data, valid the cycle after imem_req
//   redirect_valid/_pc        - flush the queue and restart fetch at redirect_pc
//   deq_ready                 - ID stage accepts the head entry
//   deq_valid/_instr/_pc      - head entry (instr is NOP when not valid)
//   deq_pc_plus4              - deq_pc + 4
//   q_count                   - occupied queue entries
module fetch_queue_unit
  import mips_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter int unsigned     IMEM_AW  = 10,
  parameter int unsigned     QDEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                        clock,
  input  logic                        reset,
  output logic                        imem_req,
  output logic [IMEM_AW-1:0]          imem_addr,
  input  logic [XLEN-1:0]             imem_rdata,
  input  logic                        redirect_valid,
  input  logic [XLEN-1:0]             redirect_pc,
  input  logic                        deq_ready,
  output logic                        deq_valid,
  output logic [XLEN-1:0]             deq_instr,
  output logic [XLEN-1:0]             deq_pc,
  output logic [XLEN-1:0]             deq_pc_plus4,
  output logic [$clog2(QDEPTH+1)-1:0] q_count
);

  localparam int unsigned     CW         = $clog2(QDEPTH + 1);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   req_pc_q;
  logic              inflight_q;
  logic              epoch_q, req_epoch_q;
  logic [CW:0]       occupancy;
  logic              push, pop;
  logic [2*XLEN-1:0] head;
  logic [XLEN-1:0]   head_instr, head_pc;

  always_comb begin
    pop = deq_valid && deq_ready && !redirect_valid;
    // Entries held plus the one in flight, minus the one leaving this edge:
    // issuing only below QDEPTH guarantees the response always has a slot.
    occupancy = (CW+1)'(q_count) + (CW+1)'(inflight_q) - (CW+1)'(pop);
    imem_req  = !reset && !redirect_valid && (occupancy < (CW+1)'(QDEPTH));
    // A response issued under an older epoch belongs to a flushed stream.
    push      = inflight_q && (req_epoch_q == epoch_q) && !redirect_valid;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid)  fetch_pc_d = redirect_pc & ALIGN_MASK;
    else if (imem_req)   fetch_pc_d = fetch_pc_q + XLEN'(4);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q  <= RESET_PC & ALIGN_MASK;
      req_pc_q    <= '0;
      inflight_q  <= 1'b0;
      epoch_q     <= 1'b0;
      req_epoch_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= imem_req;
      if (redirect_valid) epoch_q <= ~epoch_q;
      if (imem_req) begin
        req_pc_q    <= fetch_pc_q;
        req_epoch_q <= epoch_q;
      end
    end
  end

  assign imem_addr = fetch_pc_q[IMEM_AW+1:2];

  sync_fifo_flush #(
    .DEPTH (QDEPTH),
    .WIDTH (2 * XLEN)
  ) u_queue (
    .clk_i   (clock),
    .rst_i   (reset),
    .flush_i (redirect_valid),
    .push_i  (push),
    .wdata_i ({imem_rdata, req_pc_q}),
    .pop_i   (pop),
    .valid_o (deq_valid),
    .rdata_o (head),
    .count_o (q_count)
  );

  assign {head_instr, head_pc} = head;
  assign deq_instr    = deq_valid ? head_instr : XLEN'(NOP_INSTR);
  assign deq_pc       = deq_valid ? head_pc : '0;
  assign deq_pc_plus4 = deq_valid ? head_pc + XLEN'(4) : '0;

endmodule

// File: tb/tb_fetch_queue_unit.sv
module tb_fetch_queue_unit;
  import mips_pkg::*;

  localparam int QD = 4;
  localparam logic [31:0] RPC = 32'h0;

  logic        clock = 1'b0;
  logic        reset, imem_req, redirect_valid, deq_ready, deq_valid;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata, redirect_pc, deq_instr, deq_pc, deq_pc_plus4;
  logic [2:0]  q_count;

  int unsigned n_run  = 0;
  int unsigned n_fail = 0;

  // Behavioural model: ordered queue of expected entries plus one pending response.
  fetch_entry_t mq[$];
  bit           m_pend;
  logic [31:0]  m_pend_pc, m_fpc;

  fetch_queue_unit #(
    .XLEN     (32),
    .IMEM_AW  (10),
    .QDEPTH   (QD),
    .RESET_PC (RPC)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .deq_ready      (deq_ready),
    .deq_valid      (deq_valid),
    .deq_instr      (deq_instr),
    .deq_pc         (deq_pc),
    .deq_pc_plus4   (deq_pc_plus4),
    .q_count        (q_count)
  );

  always #5 clock = ~clock;

  // Instruction memory: IMEM[i] = 0x1000_0000 + i, one-cycle read latency.
  always @(posedge clock) if (imem_req) imem_rdata <= 32'h1000_0000 + {22'b0, imem_addr};

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'h1000_0000 + {22'b0, pc[11:2]};
  endfunction

  function automatic bit m_pop();
    return (mq.size() > 0) && deq_ready && !redirect_valid;
  endfunction

  function automatic bit m_req();
    int occ;
    occ = mq.size() + int'(m_pend) - int'(m_pop());
    return !reset && !redirect_valid && (occ < QD);
  endfunction

  task automatic drive(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy);
    reset = r; redirect_valid = rv; redirect_pc = rpc; deq_ready = rdy;
    #1;
  endtask

  // Advance one clock; the model steps in lockstep with the DUT.
  task automatic cycle();
    bit pop, req;
    fetch_entry_t e;
    @(posedge clock);
    pop = m_pop();
    req = m_req();
    if (reset) begin
      mq.delete(); m_pend = 0; m_fpc = RPC & ~32'h3;
    end else if (redirect_valid) begin
      mq.delete(); m_pend = 0; m_fpc = redirect_pc & ~32'h3;
    end else begin
      if (pop) void'(mq.pop_front());
      if (m_pend) begin
        e.pc = m_pend_pc; e.instr = instr_of(m_pend_pc);
        mq.push_back(e);
      end
      m_pend    = req;
      m_pend_pc = m_fpc;
      if (req) m_fpc = m_fpc + 32'd4;
    end
    @(negedge clock);
  endtask

  task automatic reset_dut();
    drive(1, 0, 32'h0, 0);
    cycle();
  endtask

  task automatic test_reset();
    reset_dut();
    drive(1, 0, 32'h0, 0);
    n_run++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
    n_run++; if (deq_valid !== 1'b0 || deq_instr !== 32'h0 || deq_pc !== 32'h0) begin
      n_fail++; $display("FAIL reset_out: got v=%b i=%h pc=%h want 0/0/0", deq_valid, deq_instr, deq_pc); end
    n_run++; if (q_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", q_count); end
    cycle();
  endtask

  task automatic test_stream();
    bit ev;
    reset_dut();
    for (int k = 0; k < 12; k++) begin
      drive(0, 0, 32'h0, 1);
      ev = (k >= 2);
      n_run++; if (imem_req !== 1'b1 || imem_addr !== 10'(k)) begin
        n_fail++; $display("FAIL stream_req k=%0d: got req=%b addr=%0d want 1/%0d", k, imem_req, imem_addr, k); end
      n_run++; if (deq_valid !== ev) begin
        n_fail++; $display("FAIL stream_valid k=%0d: got %b want %b", k, deq_valid, ev); end
      if (ev) begin
        n_run++; if (deq_pc !== 32'((k-2)*4) || deq_instr !== 32'h1000_0000 + 32'(k-2)
                     || deq_pc_plus4 !== 32'((k-2)*4 + 4)) begin
          n_fail++; $display("FAIL stream_data k=%0d: got pc=%h i=%h p4=%h want pc=%h i=%h",
                             k, deq_pc, deq_instr, deq_pc_plus4, 32'((k-2)*4), 32'h1000_0000 + 32'(k-2)); end
      end
      cycle();
    end
  endtask

  task automatic test_backpressure();
    reset_dut();
    for (int k = 0; k < 14; k++) begin
      drive(0, 0, 32'h0, k < 4);
      if (k == 13) begin
        n_run++; if (q_count !== 3'd4 || imem_req !== 1'b0) begin
          n_fail++; $display("FAIL bp_full: got count=%0d req=%b want 4/0", q_count, imem_req); end
        n_run++; if (deq_valid !== 1'b1 || deq_pc !== 32'h8) begin
          n_fail++; $display("FAIL bp_head: got v=%b pc=%h want 1/8", deq_valid, deq_pc); end
      end
      cycle();
    end
    for (int j = 0; j < 8; j++) begin
      drive(0, 0, 32'h0, 1);
      n_run++; if (deq_valid !== 1'b1 || deq_pc !== 32'(8 + 4*j) || deq_instr !== instr_of(32'(8 + 4*j))) begin
        n_fail++; $display("FAIL bp_resume j=%0d: got v=%b pc=%h i=%h want 1/%h", j, deq_valid, deq_pc, deq_instr, 32'(8 + 4*j)); end
      cycle();
    end
  endtask

  task automatic test_redirect();
    reset_dut();
    for (int k = 0; k < 4; k++) begin drive(0, 0, 32'h0, 0); cycle(); end
    drive(0, 1, 32'h0000_0043, 0);
    n_run++; if (q_count !== 3'd3 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL redir_pre: got count=%0d req=%b want 3/0", q_count, imem_req); end
    cycle();
    drive(0, 0, 32'h0, 1);
    n_run++; if (q_count !== 3'd0 || deq_valid !== 1'b0) begin
      n_fail++; $display("FAIL redir_flush: got count=%0d v=%b want 0/0", q_count, deq_valid); end
    n_run++; if (imem_req !== 1'b1 || imem_addr !== 10'd16) begin
      n_fail++; $display("FAIL redir_addr: got req=%b addr=%0d want 1/16", imem_req, imem_addr); end
    cycle();
    drive(0, 0, 32'h0, 1);
    n_run++; if (q_count !== 3'd0 || deq_valid !== 1'b0) begin
      n_fail++; $display("FAIL redir_kill: got count=%0d v=%b want 0/0", q_count, deq_valid); end
    cycle();
    drive(0, 0, 32'h0, 1);
    n_run++; if (deq_valid !== 1'b1 || deq_pc !== 32'h40 || deq_instr !== 32'h1000_0010) begin
      n_fail++; $display("FAIL redir_target: got v=%b pc=%h i=%h want 1/40/10000010", deq_valid, deq_pc, deq_instr); end
    cycle();
  endtask

  task automatic test_redirect_ready();
    reset_dut();
    for (int k = 0; k < 5; k++) begin drive(0, 0, 32'h0, 0); cycle(); end
    drive(0, 1, 32'h0000_0100, 1);
    n_run++; if (q_count !== 3'd4 || deq_pc !== 32'h0 || deq_valid !== 1'b1) begin
      n_fail++; $display("FAIL rr_full: got count=%0d v=%b pc=%h want 4/1/0", q_count, deq_valid, deq_pc); end
    cycle();
    drive(0, 0, 32'h0, 1);
    n_run++; if (q_count !== 3'd0 || imem_req !== 1'b1 || imem_addr !== 10'h40) begin
      n_fail++; $display("FAIL rr_flush: got count=%0d req=%b addr=%0d want 0/1/64", q_count, imem_req, imem_addr); end
    cycle();
    drive(0, 0, 32'h0, 1);
    n_run++; if (deq_valid !== 1'b0) begin n_fail++; $display("FAIL rr_gap: got v=%b want 0", deq_valid); end
    cycle();
    for (int j = 0; j < 4; j++) begin
      drive(0, 0, 32'h0, 1);
      n_run++; if (deq_valid !== 1'b1 || deq_pc !== 32'(32'h100 + 4*j)) begin
        n_fail++; $display("FAIL rr_seq j=%0d: got v=%b pc=%h want 1/%h", j, deq_valid, deq_pc, 32'(32'h100 + 4*j)); end
      cycle();
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    drive(0, 1, 32'h0000_0200, 0); cycle();
    for (int k = 1; k < 5; k++) begin drive(0, 0, 32'h0, 0); cycle(); end
    drive(1, 0, 32'h0, 0);
    n_run++; if (q_count !== 3'd3 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL rmid_pre: got count=%0d req=%b want 3/0", q_count, imem_req); end
    cycle();
    drive(0, 0, 32'h0, 1);
    n_run++; if (deq_valid !== 1'b0 || deq_instr !== 32'h0 || deq_pc !== 32'h0 || deq_pc_plus4 !== 32'h0 || q_count !== 3'd0) begin
      n_fail++; $display("FAIL rmid_zero: got v=%b i=%h pc=%h p4=%h c=%0d want all 0", deq_valid, deq_instr, deq_pc, deq_pc_plus4, q_count); end
    n_run++; if (imem_req !== 1'b1 || imem_addr !== 10'd0) begin
      n_fail++; $display("FAIL rmid_fetch: got req=%b addr=%0d want 1/0", imem_req, imem_addr); end
    cycle();
    drive(0, 0, 32'h0, 1);
    n_run++; if (deq_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_stale: got v=%b pc=%h want 0", deq_valid, deq_pc); end
    cycle();
    for (int j = 0; j < 4; j++) begin
      drive(0, 0, 32'h0, 1);
      n_run++; if (deq_valid !== 1'b1 || deq_pc !== 32'(4*j) || deq_instr !== 32'h1000_0000 + 32'(j)) begin
        n_fail++; $display("FAIL rmid_seq j=%0d: got v=%b pc=%h i=%h want 1/%h", j, deq_valid, deq_pc, deq_instr, 32'(4*j)); end
      cycle();
    end
  endtask

  task automatic test_wrap();
    logic [9:0]  ea [4];
    logic [31:0] ep [4];
    ea[0] = 10'd1022; ea[1] = 10'd1023; ea[2] = 10'd0; ea[3] = 10'd1;
    ep[0] = 32'hFFFF_FFF8; ep[1] = 32'hFFFF_FFFC; ep[2] = 32'h0; ep[3] = 32'h4;
    reset_dut();
    drive(0, 1, 32'hFFFF_FFF8, 1); cycle();
    for (int k = 1; k <= 6; k++) begin
      drive(0, 0, 32'h0, 1);
      if (k <= 4) begin
        n_run++; if (imem_req !== 1'b1 || imem_addr !== ea[k-1]) begin
          n_fail++; $display("FAIL wrap_addr k=%0d: got req=%b addr=%0d want 1/%0d", k, imem_req, imem_addr, ea[k-1]); end
      end
      if (k >= 3) begin
        n_run++; if (deq_valid !== 1'b1 || deq_pc !== ep[k-3] || deq_pc_plus4 !== ep[k-3] + 32'd4
                     || deq_instr !== 32'h1000_0000 + {22'b0, ea[k-3]}) begin
          n_fail++; $display("FAIL wrap_deq k=%0d: got v=%b pc=%h p4=%h i=%h want pc=%h", k, deq_valid, deq_pc, deq_pc_plus4, deq_instr, ep[k-3]); end
      end
      cycle();
    end
  endtask

  task automatic test_random();
    bit          r, rv, rdy, ev, er;
    logic [31:0] rpc, epc, ei;
    for (int c = 0; c < 800; c++) begin
      r   = ($urandom_range(0, 99) < 2);
      rv  = ($urandom_range(0, 99) < 6);
      rdy = ($urandom_range(0, 99) < 65);
      rpc = $urandom;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFE0 | 32'($urandom_range(0, 31));
      drive(r, rv, rpc, rdy);
      ev  = (mq.size() > 0);
      epc = ev ? mq[0].pc : 32'h0;
      ei  = ev ? mq[0].instr : NOP_INSTR;
      er  = m_req();
      n_run++; if (imem_req !== er || (er && imem_addr !== m_fpc[11:2])) begin
        n_fail++; $display("FAIL rand_req c=%0d: got req=%b addr=%0d want %b/%0d", c, imem_req, imem_addr, er, m_fpc[11:2]); end
      n_run++; if (deq_valid !== ev || deq_pc !== epc || deq_instr !== ei
                   || deq_pc_plus4 !== (ev ? epc + 32'd4 : 32'h0)) begin
        n_fail++; $display("FAIL rand_deq c=%0d: got v=%b pc=%h i=%h p4=%h want %b/%h/%h", c, deq_valid, deq_pc, deq_instr, deq_pc_plus4, ev, epc, ei); end
      n_run++; if (q_count !== 3'(mq.size())) begin
        n_fail++; $display("FAIL rand_count c=%0d: got %0d want %0d", c, q_count, mq.size()); end
      cycle();
    end
  endtask

  initial begin
    imem_rdata = 32'h0;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; deq_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_ready();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
